// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared policy constants and next-state function for the SR flip-flop bank
package sr_pkg;

  localparam int unsigned SR_BOTH_CLEAR  = 0;
  localparam int unsigned SR_BOTH_SET    = 1;
  localparam int unsigned SR_BOTH_HOLD   = 2;
  localparam int unsigned SR_BOTH_TOGGLE = 3;

  // Pure next-state of one SR bit; policy only matters when s and r are both high.
  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input int unsigned policy);
    logic nxt;
    case ({s, r})
      2'b00:   nxt = q;
      2'b10:   nxt = 1'b1;
      2'b01:   nxt = 1'b0;
      default: begin
        case (policy)
          SR_BOTH_CLEAR: nxt = 1'b0;
          SR_BOTH_SET:   nxt = 1'b1;
          SR_BOTH_HOLD:  nxt = q;
          default:       nxt = ~q;
        endcase
      end
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_bit_cell.sv
// rtl/sr_bit_cell.sv - one SR storage bit with synchronous reset and S=R=1 policy mux
module sr_bit_cell
  import sr_pkg::*;
#(
  parameter int unsigned POLICY = SR_BOTH_CLEAR
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic s_i,
  input  logic r_i,
  output logic q_o,
  output logic invalid_o
);

  logic q_q, q_d;
  logic inv_q, inv_d;

  always_comb begin
    q_d   = sr_next(q_q, s_i, r_i, POLICY);
    inv_d = s_i & r_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      q_q   <= 1'b0;
      inv_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      inv_q <= inv_d;
    end
  end

  assign q_o       = q_q;
  assign invalid_o = inv_q;

endmodule

// File: rtl/sr_flip_flop.sv
// rtl/sr_flip_flop.sv - WIDTH-bit SR flip-flop bank with invalid-input flags
module sr_flip_flop
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned BOTH_POLICY = SR_BOTH_CLEAR
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] invalid,
  output logic             invalid_seen
);

  if (BOTH_POLICY > SR_BOTH_TOGGLE) begin : g_bad_policy
    $error("sr_flip_flop: BOTH_POLICY must be 0..3");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("sr_flip_flop: WIDTH must be at least 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_bit_cell #(
      .POLICY(BOTH_POLICY)
    ) u_cell (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .s_i      (s[i]),
      .r_i      (r[i]),
      .q_o      (q[i]),
      .invalid_o(invalid[i])
    );
  end

  // Sticky flag rises on the same edge as the first invalid bit.
  logic seen_q, seen_d;

  always_comb seen_d = seen_q | (|(s & r));

  always_ff @(posedge clk) begin
    if (!rst_n) seen_q <= 1'b0;
    else        seen_q <= seen_d;
  end

  assign qn           = ~q;
  assign invalid_seen = seen_q;

endmodule

// File: tb/tb_sr_flip_flop.sv
// tb/tb_sr_flip_flop.sv - directed self-checking bench for sr_flip_flop
module tb_sr_flip_flop;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] s_p, r_p, q_p, qn_p, inv_p, seen_p;
  logic [3:0] s_w, r_w, q_w, qn_w, inv_w;
  logic       seen_w;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_flip_flop #(.WIDTH(1), .BOTH_POLICY(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .s(s_p[0]), .r(r_p[0]), .q(q_p[0]), .qn(qn_p[0]),
    .invalid(inv_p[0]), .invalid_seen(seen_p[0]));
  sr_flip_flop #(.WIDTH(1), .BOTH_POLICY(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .s(s_p[1]), .r(r_p[1]), .q(q_p[1]), .qn(qn_p[1]),
    .invalid(inv_p[1]), .invalid_seen(seen_p[1]));
  sr_flip_flop #(.WIDTH(1), .BOTH_POLICY(2)) u_p2 (
    .clk(clk), .rst_n(rst_n), .s(s_p[2]), .r(r_p[2]), .q(q_p[2]), .qn(qn_p[2]),
    .invalid(inv_p[2]), .invalid_seen(seen_p[2]));
  sr_flip_flop #(.WIDTH(1), .BOTH_POLICY(3)) u_p3 (
    .clk(clk), .rst_n(rst_n), .s(s_p[3]), .r(r_p[3]), .q(q_p[3]), .qn(qn_p[3]),
    .invalid(inv_p[3]), .invalid_seen(seen_p[3]));
  sr_flip_flop #(.WIDTH(4), .BOTH_POLICY(0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .s(s_w), .r(r_w), .q(q_w), .qn(qn_w),
    .invalid(inv_w), .invalid_seen(seen_w));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seq_sr [8] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11};
  logic       seq_q  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       seq_iv [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       seq_sn [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    // reset held two edges with set requested
    rst_n = 1'b0; s_p = 4'hF; r_p = 4'h0; s_w = 4'hF; r_w = 4'h0;
    step(); step();
    check_eq("rst_q",     32'(q_p[0]),    32'd0);
    check_eq("rst_qn",    32'(qn_p[0]),   32'd1);
    check_eq("rst_inv",   32'(inv_p[0]),  32'd0);
    check_eq("rst_seen",  32'(seen_p[0]), 32'd0);
    check_eq("rst_q_w4",  32'(q_w),       32'h0);
    check_eq("rst_qn_w4", 32'(qn_w),      32'hF);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_set", 32'(q_p[0]), 32'd1);

    // default-policy sequence
    rst_n = 1'b0; s_p = 4'h0; r_p = 4'h0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_p[0] = seq_sr[i][1]; r_p[0] = seq_sr[i][0];
      step();
      check_eq($sformatf("seq_q%0d", i),    32'(q_p[0]),    32'(seq_q[i]));
      check_eq($sformatf("seq_inv%0d", i),  32'(inv_p[0]),  32'(seq_iv[i]));
      check_eq($sformatf("seq_seen%0d", i), 32'(seen_p[0]), 32'(seq_sn[i]));
    end

    // policy sweep from q=1
    s_p = 4'hF; r_p = 4'h0;
    step();
    check_eq("sweep_pre", 32'(q_p), 32'hF);
    s_p = 4'hF; r_p = 4'hF;
    step();
    check_eq("sweep_p0", 32'(q_p[0]), 32'd0);
    check_eq("sweep_p1", 32'(q_p[1]), 32'd1);
    check_eq("sweep_p2", 32'(q_p[2]), 32'd1);
    check_eq("sweep_p3", 32'(q_p[3]), 32'd0);
    check_eq("sweep_inv", 32'(inv_p), 32'hF);
    step();
    check_eq("sweep_p3_2nd", 32'(q_p[3]), 32'd1);
    check_eq("sweep_p2_2nd", 32'(q_p[2]), 32'd1);
    check_eq("sweep_p0_2nd", 32'(q_p[0]), 32'd0);

    // multi-bit independence
    rst_n = 1'b0; s_p = 4'h0; r_p = 4'h0; s_w = 4'h0; r_w = 4'h0;
    step();
    rst_n = 1'b1; s_w = 4'b1010; r_w = 4'b0110;
    step();
    check_eq("w4_q",    32'(q_w),    32'b1000);
    check_eq("w4_inv",  32'(inv_w),  32'b0010);
    check_eq("w4_qn",   32'(qn_w),   32'b0111);
    check_eq("w4_seen", 32'(seen_w), 32'd1);
    s_w = 4'b0001; r_w = 4'b1000;
    step();
    check_eq("w4_q2",    32'(q_w),    32'b0001);
    check_eq("w4_inv2",  32'(inv_w),  32'b0000);
    check_eq("w4_seen2", 32'(seen_w), 32'd1);

    // reset mid-operation
    s_p[0] = 1'b1; r_p[0] = 1'b1;
    step();
    s_p[0] = 1'b1; r_p[0] = 1'b0;
    step();
    check_eq("mid_pre_q",    32'(q_p[0]),    32'd1);
    check_eq("mid_pre_seen", 32'(seen_p[0]), 32'd1);
    rst_n = 1'b0;
    step();
    check_eq("mid_q",    32'(q_p[0]),    32'd0);
    check_eq("mid_seen", 32'(seen_p[0]), 32'd0);
    check_eq("mid_inv",  32'(inv_p[0]),  32'd0);

    // glitch between edges must not reach q
    rst_n = 1'b1; s_p[0] = 1'b0; r_p[0] = 1'b0;
    #1 s_p[0] = 1'b1; r_p[0] = 1'b1;
    #1 check_eq("glitch_nochg", 32'(q_p[0]), 32'd0);
    s_p[0] = 1'b0; r_p[0] = 1'b0;
    step();
    check_eq("glitch_q",    32'(q_p[0]),    32'd0);
    check_eq("glitch_seen", 32'(seen_p[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
